// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back, write-allocate word cache with a 128-bit line memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_direct_wb #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 30 - IDX_W - 2
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   stat_hit,
  output logic [31:0]   stat_miss
`endif
);

  localparam int unsigned Lines = 2 ** IDX_W;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [Lines];
  logic [127:0]      data_q [Lines];

  logic              mem_read_q, mem_write_q;
  logic [27:0]       mem_addr_q;
  logic [127:0]      mem_wdata_q;
  logic              fill_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        off;
  logic              req, hit, victim_dirty;
  logic              wr_en, fill_en;

  assign off          = proc_addr[1:0];
  assign idx          = proc_addr[IDX_W+1:2];
  assign tag          = proc_addr[29:IDX_W+2];
  assign req          = proc_read | proc_write;
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            wr_en = proc_write;
            if (proc_read) proc_rdata = data_q[idx][{off, 5'd0} +: 32];
          end else begin
            proc_stall = 1'b1;
            state_d    = victim_dirty ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        proc_stall = 1'b1;
        if (mem_ready) state_d = StAllocate;
      end
      StAllocate: begin
        proc_stall = 1'b1;
        fill_en    = mem_ready;
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset forces quiet outputs and blocks any storage update in that cycle.
    if (proc_reset) begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      wr_en      = 1'b0;
      fill_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_en;
      unique case (state_q)
        StIdle: begin
          if (wr_en) dirty_q[idx] <= 1'b1;
          if (req && !hit) begin
            if (victim_dirty) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= data_q[idx];
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= proc_addr[29:2];
            end
          end
        end
        StWriteback: begin
          if (mem_ready) begin
            mem_write_q  <= 1'b0;
            dirty_q[idx] <= 1'b0;
            mem_read_q   <= 1'b1;
            mem_addr_q   <= proc_addr[29:2];
          end
        end
        StAllocate: begin
          if (mem_ready) begin
            mem_read_q   <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_en) begin
      data_q[idx][{off, 5'd0} +: 32] <= proc_wdata;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (state_q == StIdle && req) begin
      // The hit that completes a refilled request belongs to that miss.
      if (hit && !fill_q && stat_hit_q != 32'hFFFF_FFFF) stat_hit_q <= stat_hit_q + 32'd1;
      if (!hit && stat_miss_q != 32'hFFFF_FFFF) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb: table of zero-wait hit vectors plus hand-written miss,
// write-back, stalled-refill and reset-abort sequences against a fixed-latency memory model.
module tb_dcache_direct_wb;

  logic          clk = 1'b0;
  logic          proc_reset, proc_read, proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata, proc_rdata;
  logic          proc_stall, mem_read, mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata, mem_rdata;
  logic          mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_hit, stat_miss;
`endif

  int nvec = 0;
  int nfail = 0;

  dcache_direct_wb dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit   (stat_hit),
    .stat_miss  (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word at word address a holds {2'b10, a}; ready pulses in the 4th strobe cycle.
  int   lat = 4;
  int   cnt = 0;
  logic hold_ready = 1'b0;

  assign mem_rdata = {2'b10, mem_addr, 2'd3, 2'b10, mem_addr, 2'd2,
                      2'b10, mem_addr, 2'd1, 2'b10, mem_addr, 2'd0};

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (!(mem_read || mem_write)) cnt <= 0;
    else if (!mem_ready && !hold_ready) begin
      if (cnt >= lat - 2) begin
        mem_ready <= 1'b1;
        cnt       <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Strobe monitor: counts rising edges and latches their address / data.
  int           nreads = 0;
  int           nwrites = 0;
  logic         rd_prev = 1'b0;
  logic         wr_prev = 1'b0;
  logic [27:0]  rd_addr = '0;
  logic [27:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;

  always @(posedge clk) begin
    rd_prev <= mem_read;
    wr_prev <= mem_write;
    if (mem_read && !rd_prev) begin
      nreads  <= nreads + 1;
      rd_addr <= mem_addr;
    end
    if (mem_write && !wr_prev) begin
      nwrites <= nwrites + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called in a sampled cycle; returns the number of stalled cycles before completion.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (proc_stall && cycles < budget) begin
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    proc_read  = r;
    proc_write = w;
    proc_addr  = a;
    proc_wdata = d;
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc;
    int hits;
    int r0, w0;

    vecs[0] = '{1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 30'h11, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 30'h10, 32'h0,         32'h8000_0010};
    vecs[3] = '{1'b1, 1'b0, 30'h13, 32'h0,         32'h8000_0013};
    vecs[4] = '{1'b0, 1'b1, 30'h12, 32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 30'h12, 32'h0,         32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b0, 30'h12, 32'h0,         32'h0};

    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    proc_reset = 1'b0;

    // Cold read miss of line 0x4.
    drive(1'b1, 1'b0, 30'h10, 32'h0);
    chk("miss_stall_comb", proc_stall, 1);
    wait_done(50, cyc);
    chk("miss_stall_cycles", cyc, 5);
    chk("miss_nreads", nreads, 1);
    chk("miss_rd_addr", rd_addr, 28'h4);
    chk("miss_rdata", proc_rdata, 32'h8000_0010);
    drive(1'b0, 1'b0, 30'h10, 32'h0);

    // Zero-wait hits from the table.
    r0 = nreads;
    w0 = nwrites;
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_stall", i), proc_stall, 0);
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), proc_rdata, vecs[i].exp_rdata);
      if (vecs[i].rd || vecs[i].wr) hits++;
    end
    // Both strobes high behaves as a write.
    drive(1'b1, 1'b1, 30'h13, 32'h5555_AAAA);
    chk("rw_stall", proc_stall, 0);
    drive(1'b1, 1'b0, 30'h13, 32'h0);
    chk("rw_readback", proc_rdata, 32'h5555_AAAA);
    hits += 2;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    chk("hits_no_mem", {nreads - r0, nwrites - w0}, 0);

    // Conflict miss on dirty index 4: write-back of tag 0 then refill of line 0xC.
    drive(1'b1, 1'b0, 30'h31, 32'h0);
    chk("wb_stall_comb", proc_stall, 1);
    wait_done(50, cyc);
    chk("wb_stall_cycles", cyc, 9);
    chk("wb_nwrites", nwrites - w0, 1);
    chk("wb_addr", wr_addr, 28'h4);
    chk("wb_data", wr_data, {32'h5555_AAAA, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h8000_0010});
    chk("wb_nreads", nreads - r0, 1);
    chk("wb_rd_addr", rd_addr, 28'hC);
    chk("wb_rdata", proc_rdata, 32'h8000_0031);
    drive(1'b0, 1'b0, 30'h0, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("stat_hit", stat_hit, hits);
    chk("stat_miss", stat_miss, 2);
`endif

    // Write miss allocates, then the write lands.
    drive(1'b0, 1'b1, 30'h1D, 32'h1234_5678);
    wait_done(50, cyc);
    chk("wmiss_stall_cycles", cyc, 5);
    drive(1'b1, 1'b0, 30'h1D, 32'h0);
    chk("wmiss_readback", proc_rdata, 32'h1234_5678);
    drive(1'b1, 1'b0, 30'h1C, 32'h0);
    chk("wmiss_neighbour", proc_rdata, 32'h8000_001C);

    // Refill held off for 20 cycles.
    hold_ready = 1'b1;
    drive(1'b1, 1'b0, 30'h08, 32'h0);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!(mem_read && proc_stall && mem_addr == 28'h2)) cyc++;
    end
    chk("hold_bad_cycles", cyc, 0);
    hold_ready = 1'b0;
    wait_done(50, cyc);
    chk("hold_release", proc_stall, 0);
    chk("hold_rdata", proc_rdata, 32'h8000_0008);
    drive(1'b0, 1'b0, 30'h0, 32'h0);

    // Reset during a refill abandons it and invalidates everything.
    hold_ready = 1'b1;
    drive(1'b1, 1'b0, 30'h20, 32'h0);
    repeat (2) @(negedge clk);
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_stall", proc_stall, 0);
    chk("abort_mem_addr", mem_addr, 0);
    proc_reset = 1'b0;
    hold_ready = 1'b0;
    drive(1'b1, 1'b0, 30'h10, 32'h0);
    chk("abort_now_miss", proc_stall, 1);
    wait_done(50, cyc);
    chk("abort_refill_cycles", cyc, 5);
    chk("abort_rdata", proc_rdata, 32'h8000_0010);
    drive(1'b0, 1'b0, 30'h0, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("stat_after_reset", {stat_hit, stat_miss}, {32'd0, 32'd1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
